// File: rtl/string_led_sequencer.sv
// string_led_sequencer: streams buffer bytes from SRAM port 1
// as a pulse-width-coded single-wire LED bitstream.
module string_led_sequencer #(
  parameter int ASIZE        = 32,
  parameter int TSIZE        = 8,
  parameter int RESET_CYCLES = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             controller_en,
  input  logic             polarity,
  input  logic [TSIZE-1:0] t_period,
  input  logic [TSIZE-1:0] t0_high,
  input  logic [TSIZE-1:0] t1_high,
  input  logic [3:0]       w_count,
  input  logic [ASIZE-1:0] w_first,
  input  logic [ASIZE-1:0] w_last,
  input  logic             start,
  output logic             progress,
  output logic             cs_n,
  output logic [ASIZE-1:0] addr,
  input  logic [7:0]       rdata,
  output logic             led_out
);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, BIT, LATCH
  } state_t;

  state_t           state;
  logic             pol_q;
  logic [TSIZE-1:0] per_q;
  logic [TSIZE-1:0] h0_q;
  logic [TSIZE-1:0] h1_q;
  logic [ASIZE-1:0] first_q;
  logic [ASIZE-1:0] last_q;
  logic [3:0]       passes;
  logic [7:0]       shift;
  logic [7:0]       hold;
  logic [2:0]       bidx;
  logic [TSIZE-1:0] cnt;
  logic [LW-1:0]    lcnt;
  logic             more;

  logic [TSIZE-1:0] per_in;
  logic [TSIZE-1:0] cnt_nx;
  logic [TSIZE-1:0] h_cur;
  logic [TSIZE-1:0] h_nb;
  logic [TSIZE-1:0] h_rd;
  logic [ASIZE-1:0] nxt_addr;
  logic             at_end;
  logic             nb;
  logic             wrap;
  logic             nxt_more;

  always_comb begin
    per_in   = (t_period < TSIZE'(3)) ? TSIZE'(3) : t_period;
    cnt_nx   = cnt + 1'b1;
    at_end   = (cnt == per_q);
    h_cur    = shift[bidx] ? h1_q : h0_q;
    nb       = (bidx == 3'd0) ? hold[7] : shift[bidx - 3'd1];
    h_nb     = nb ? h1_q : h0_q;
    h_rd     = rdata[7] ? h1_q : h0_q;
    wrap     = (addr == last_q);
    nxt_addr = wrap ? first_q : addr + 1'b1;
    nxt_more = !wrap || (passes > 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      progress <= 1'b0;
      cs_n     <= 1'b1;
      addr     <= '0;
      led_out  <= 1'b0;
      pol_q    <= 1'b0;
      per_q    <= '0;
      h0_q     <= '0;
      h1_q     <= '0;
      first_q  <= '0;
      last_q   <= '0;
      passes   <= '0;
      shift    <= '0;
      hold     <= '0;
      bidx     <= '0;
      cnt      <= '0;
      lcnt     <= '0;
      more     <= 1'b0;
    end else if (!controller_en) begin
      state    <= IDLE;
      progress <= 1'b0;
      cs_n     <= 1'b1;
      led_out  <= polarity;
    end else begin
      unique case (state)
        IDLE: begin
          led_out <= polarity;
          if (start) begin
            pol_q    <= polarity;
            per_q    <= per_in;
            h0_q     <= t0_high;
            h1_q     <= t1_high;
            first_q  <= w_first;
            last_q   <= w_last;
            passes   <= (w_count == 4'd0) ? 4'd1 : w_count;
            progress <= 1'b1;
            lcnt     <= '0;
            if (w_first > w_last) begin
              state <= LATCH;
            end else begin
              state <= FETCH;
              addr  <= w_first;
              cs_n  <= 1'b0;
            end
          end
        end
        FETCH: begin
          cs_n    <= 1'b1;
          led_out <= pol_q;
          state   <= LOAD;
        end
        LOAD: begin
          shift   <= rdata;
          bidx    <= 3'd7;
          cnt     <= '0;
          led_out <= pol_q ^ (h_rd != '0);
          state   <= BIT;
        end
        BIT: begin
          cs_n <= 1'b1;
          // next byte is fetched during bit 0 so the stream has no gap
          if (bidx == 3'd0 && cnt == '0) begin
            more <= nxt_more;
            if (nxt_more) begin
              cs_n <= 1'b0;
              addr <= nxt_addr;
              if (wrap) passes <= passes - 4'd1;
            end
          end
          if (bidx == 3'd0 && cnt == TSIZE'(2) && more)
            hold <= rdata;
          if (at_end) begin
            cnt <= '0;
            if (bidx == 3'd0 && !more) begin
              state   <= LATCH;
              lcnt    <= '0;
              led_out <= pol_q;
            end else begin
              bidx    <= bidx - 3'd1;
              if (bidx == 3'd0) shift <= hold;
              led_out <= pol_q ^ (h_nb != '0);
            end
          end else begin
            cnt     <= cnt_nx;
            led_out <= pol_q ^ (cnt_nx < h_cur);
          end
        end
        LATCH: begin
          led_out <= pol_q;
          if (lcnt == LW'(RESET_CYCLES)) begin
            state    <= IDLE;
            progress <= 1'b0;
          end else begin
            lcnt <= lcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
